// File: rtl/cache_perf_monitor.sv
// Per-channel cache performance counters (accesses, misses, stall cycles) with
// atomic snapshot shadows and a registered read port. Optional PERF_MAX_STALL_EN
// adds a per-channel longest-stall-run register readable as rd_type 4.

module cache_perf_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             stall,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] sh_acc,
  output logic [CNT_W-1:0] sh_miss,
  output logic [CNT_W-1:0] sh_stl,
  output logic [CNT_W-1:0] sh_max,
  output logic [2:0]       sh_ovf,
  output logic [2:0]       ovf
);
  localparam logic [CNT_W-1:0] MAXV = {CNT_W{1'b1}};

  logic             req_q, stall_q;
  logic [CNT_W-1:0] acc, miss, stl;
  logic             acc_ev, miss_ev;

  assign acc_ev  = req & ~req_q;
  assign miss_ev = stall & ~stall_q;

  // clr wins over the old value but not over a coincident event (loads 1).
  function automatic logic [CNT_W-1:0] nxt(input logic [CNT_W-1:0] c,
                                           input logic ev, input logic cl);
    if (cl)                 return ev ? CNT_W'(1) : '0;
    else if (ev && c != MAXV) return c + CNT_W'(1);
    else                    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      stall_q <= 1'b0;
      acc     <= '0;
      miss    <= '0;
      stl     <= '0;
      ovf     <= '0;
      sh_acc  <= '0;
      sh_miss <= '0;
      sh_stl  <= '0;
      sh_ovf  <= '0;
    end else begin
      req_q   <= req;
      stall_q <= stall;
      acc     <= nxt(acc,  acc_ev,  clr);
      miss    <= nxt(miss, miss_ev, clr);
      stl     <= nxt(stl,  stall,   clr);
      if (clr) ovf <= '0;
      else     ovf <= ovf | {stall & (stl == MAXV), miss_ev & (miss == MAXV),
                             acc_ev & (acc == MAXV)};
      if (snap) begin
        sh_acc  <= acc;
        sh_miss <= miss;
        sh_stl  <= stl;
        sh_ovf  <= ovf;
      end
    end
  end

`ifdef PERF_MAX_STALL_EN
  logic [CNT_W-1:0] run, run_n, mx;

  assign run_n = !stall ? '0 : (run == MAXV) ? run : run + CNT_W'(1);

  // Max tracks the ongoing run as well, so a snapshot mid-stall sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= '0;
      mx     <= '0;
      sh_max <= '0;
    end else begin
      run <= run_n;
      if (clr)             mx <= '0;
      else if (run_n > mx) mx <= run_n;
      if (snap) sh_max <= mx;
    end
  end
`else
  assign sh_max = '0;
`endif
endmodule

module cache_perf_monitor #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_read,
  input  logic [NUM_CH-1:0] ch_write,
  input  logic [NUM_CH-1:0] ch_stall,
  input  logic              clr,
  input  logic              snap,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_ch,
  input  logic [2:0]        rd_type,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              any_ovf
);
  logic [NUM_CH-1:0][CNT_W-1:0] sh_acc, sh_miss, sh_stl, sh_max;
  logic [NUM_CH-1:0][2:0]       sh_ovf, ovf;
  logic [CNT_W-1:0]             rd_mux;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cache_perf_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .req     (ch_read[g] | ch_write[g]),
      .stall   (ch_stall[g]),
      .clr     (clr),
      .snap    (snap),
      .sh_acc  (sh_acc[g]),
      .sh_miss (sh_miss[g]),
      .sh_stl  (sh_stl[g]),
      .sh_max  (sh_max[g]),
      .sh_ovf  (sh_ovf[g]),
      .ovf     (ovf[g])
    );
  end

  assign any_ovf = |ovf;

  // Out-of-range channel or type falls through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == SEL_W'(i)) begin
        case (rd_type)
          3'd0:    rd_mux = sh_acc[i];
          3'd1:    rd_mux = sh_miss[i];
          3'd2:    rd_mux = sh_stl[i];
          3'd3:    rd_mux = {{(CNT_W-3){1'b0}}, sh_ovf[i]};
          3'd4:    rd_mux = sh_max[i];
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_cache_perf_monitor.sv
// Scoreboard bench for cache_perf_monitor (NUM_CH=2, CNT_W=8).
module tb_cache_perf_monitor;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] ch_read = '0, ch_write = '0, ch_stall = '0;
  logic              clr = 1'b0, snap = 1'b0, rd_en = 1'b0;
  logic [SEL_W-1:0]  rd_ch = '0;
  logic [2:0]        rd_type = '0;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid, any_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_q[$];

  cache_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
    .ch_stall(ch_stall), .clr(clr), .snap(snap), .rd_en(rd_en),
    .rd_ch(rd_ch), .rd_type(rd_type), .rd_data(rd_data),
    .rd_valid(rd_valid), .any_ovf(any_ovf)
  );

  always #5 clk = ~clk;

  // Read: d/v sampled one cycle after rd_en, d2/v2 one cycle later still.
  task automatic rd(input int ch, input int typ, output logic [CNT_W-1:0] d,
                    output logic v, output logic [CNT_W-1:0] d2, output logic v2);
    @(negedge clk); rd_en = 1'b1; rd_ch = SEL_W'(ch); rd_type = 3'(typ);
    @(negedge clk); rd_en = 1'b0; d = rd_data; v = rd_valid;
    @(negedge clk); d2 = rd_data; v2 = rd_valid;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_snap_clr(input logic s, input logic c);
    @(negedge clk); snap = s; clr = c;
    @(negedge clk); snap = 1'b0; clr = 1'b0;
  endtask

  task automatic acc_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ch_read[0] = 1'b1;
      @(negedge clk); ch_read[0] = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || any_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%0d valid=%0b ovf=%0b want 0/0/0", rd_data, rd_valid, any_ovf);
    end
    cyc(2); rst = 1'b0; cyc(1);
  endtask

  task automatic test_access();
    logic [CNT_W-1:0] d, d2, e; logic v, v2;
    @(negedge clk); ch_read[0] = 1'b1; cyc(5);
    ch_read[0] = 1'b0; cyc(1);
    ch_read[0] = 1'b1; cyc(3);
    ch_read[0] = 1'b0; cyc(1);
    pulse_snap_clr(1'b1, 1'b0);
    exp_q.push_back(CNT_W'(2));
    rd(0, 0, d, v, d2, v2);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || v !== 1'b1) begin
      n_fail++; $display("FAIL access_ch0: got %0d valid=%0b want %0d valid=1", d, v, e);
    end
    n_tests++;
    if (v2 !== 1'b0 || d2 !== e) begin
      n_fail++; $display("FAIL rd_valid_pulse_hold: got valid=%0b data=%0d want 0/%0d", v2, d2, e);
    end
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] d, d2, e; logic v, v2;
    @(negedge clk); ch_stall[1] = 1'b1; cyc(4);
    ch_stall[1] = 1'b0; cyc(2);
    ch_stall[1] = 1'b1; cyc(3);
    ch_stall[1] = 1'b0; cyc(1);
    pulse_snap_clr(1'b1, 1'b0);
    exp_q.push_back(CNT_W'(2));
    exp_q.push_back(CNT_W'(7));
`ifdef PERF_MAX_STALL_EN
    exp_q.push_back(CNT_W'(4));
`else
    exp_q.push_back(CNT_W'(0));
`endif
    rd(1, 1, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL miss_ch1: got %0d want %0d", d, e); end
    rd(1, 2, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL stall_cycles_ch1: got %0d want %0d", d, e); end
    rd(1, 4, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL max_run_ch1: got %0d want %0d", d, e); end
  endtask

  task automatic test_overflow();
    logic [CNT_W-1:0] d, d2, e; logic v, v2;
    pulse_snap_clr(1'b0, 1'b1);
    acc_pulses(260);
    n_tests++;
    if (any_ovf !== 1'b1) begin n_fail++; $display("FAIL any_ovf_set: got %0b want 1", any_ovf); end
    pulse_snap_clr(1'b1, 1'b0);
    exp_q.push_back(CNT_W'(255));
    exp_q.push_back(CNT_W'(1));
    rd(0, 0, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL saturate_ch0: got %0d want %0d", d, e); end
    rd(0, 3, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL ovf_flags_ch0: got %0d want %0d", d, e); end
    pulse_snap_clr(1'b0, 1'b1);
    n_tests++;
    if (any_ovf !== 1'b0) begin n_fail++; $display("FAIL any_ovf_clr: got %0b want 0", any_ovf); end
  endtask

  task automatic test_snap_clear();
    logic [CNT_W-1:0] d, d2, e; logic v, v2;
    pulse_snap_clr(1'b0, 1'b1);
    acc_pulses(10);
    pulse_snap_clr(1'b1, 1'b1);
    acc_pulses(3);
    exp_q.push_back(CNT_W'(10));
    rd(0, 0, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL snap_clr_shadow: got %0d want %0d", d, e); end
    pulse_snap_clr(1'b1, 1'b0);
    exp_q.push_back(CNT_W'(3));
    rd(0, 0, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL post_clear_count: got %0d want %0d", d, e); end
  endtask

  task automatic test_clr_event();
    logic [CNT_W-1:0] d, d2, e; logic v, v2;
    @(negedge clk); ch_read[0] = 1'b1; clr = 1'b1;
    @(negedge clk); ch_read[0] = 1'b0; clr = 1'b0;
    pulse_snap_clr(1'b1, 1'b0);
    exp_q.push_back(CNT_W'(1));
    exp_q.push_back(CNT_W'(0));
    exp_q.push_back(CNT_W'(0));
    rd(0, 0, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL clr_with_event: got %0d want %0d", d, e); end
    rd(5, 0, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e || v !== 1'b1) begin
      n_fail++; $display("FAIL bad_channel: got %0d valid=%0b want %0d valid=1", d, v, e);
    end
    rd(0, 6, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e || v !== 1'b1) begin
      n_fail++; $display("FAIL bad_type: got %0d valid=%0b want %0d valid=1", d, v, e);
    end
  endtask

  task automatic test_mid_reset();
    logic [CNT_W-1:0] d, d2, e; logic v, v2;
    acc_pulses(4);
    @(negedge clk); ch_write[0] = 1'b1;
    rd_en = 1'b1; rd_ch = '0; rd_type = 3'd2;
    @(negedge clk); rd_en = 1'b1; rd_type = 3'd0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || any_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got data=%0d valid=%0b ovf=%0b want 0/0/0", rd_data, rd_valid, any_ovf);
    end
    @(negedge clk); rd_en = 1'b0; rst = 1'b0;
    cyc(2);
    pulse_snap_clr(1'b1, 1'b0);
    exp_q.push_back(CNT_W'(1));
    rd(0, 0, d, v, d2, v2);
    e = exp_q.pop_front(); n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL reset_held_req: got %0d want %0d", d, e); end
    ch_write[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_access();
    test_stall();
    test_overflow();
    test_snap_clear();
    test_clr_event();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_perf_monitor.md
Name: cache_perf_monitor

Overview:
Parametrised, synthesizable performance-counter block for the cache hierarchy. It replaces ad-hoc testbench edge counting with per-channel hardware counters covering N processor/cache channels (I-side, D-side, L2 ports). Each channel counts accesses, misses and stall cycles. Software or the bench reads the counters through an atomic snapshot and a registered read port.

Parameters:
NUM_CH, 2, number of monitored channels (1..8)
CNT_W, 32, width of every counter (8..32)
SEL_W, 3, width of rd_ch (must satisfy 2^SEL_W >= NUM_CH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
ch_read  in  NUM_CH  per-channel read request (proc_read level)
ch_write  in  NUM_CH  per-channel write request (proc_write level)
ch_stall  in  NUM_CH  per-channel stall (proc_stall level)
clr  in  1  synchronous clear of live counters and overflow flags
snap  in  1  copy all live counters into shadow registers
rd_en  in  1  read request, one-cycle pulse
rd_ch  in  SEL_W  channel to read
rd_type  in  3  0=access, 1=miss, 2=stall cycles, 3=overflow flags, 4=max stall run (optional)
rd_data  out  CNT_W  read result
rd_valid  out  1  rd_data valid for one cycle
any_ovf  out  1  OR of all overflow flags

Behaviour:
- Reset (async, rst=1): all live and shadow counters, edge registers, overflow flags, rd_data, rd_valid and any_ovf are 0.
- Edge detection: per channel, register req_q = ch_read|ch_write and stall_q = ch_stall each cycle.
- Access event: (ch_read|ch_write) & ~req_q, a rising edge. A request held high for many cycles counts once. A read-to-write switch with no low cycle counts once.
- Miss event: ch_stall & ~stall_q, a rising edge.
- Stall cycles: +1 every cycle ch_stall=1.
- Counters saturate at 2^CNT_W-1. An event arriving at saturation sets the sticky overflow bit for that channel/type, and the counter does not wrap.
- Overflow flags per channel: bit0 access, bit1 miss, bit2 stall. rd_type=3 returns them zero-extended.
- clr: live counters and flags become 0 at the next edge. If an event occurs in the same cycle as clr, the counter loads 1, not 0. Shadow registers are unaffected by clr.
- snap: all shadow registers load the live values from before this edge's update, in one cycle, for all channels.
- snap and clr in the same cycle: the shadow captures the pre-clear values and the live counters clear. This is an atomic snap-and-clear.
- Read: rd_en at edge k gives rd_data/rd_valid valid after edge k+1, a latency of 1 cycle. rd_valid is high for exactly one cycle.
- Reads always return shadow values, never live counters.
- rd_ch >= NUM_CH, or rd_type 5..7, returns 0 with rd_valid=1.
- rd_data holds its last value while rd_valid=0.
- rst asserted mid-operation: everything clears immediately. Edge registers clear too, so a request still high when rst deasserts counts as a new access on the first active edge.
- Edge detection is not gated by clr or snap.

Optional Feature:
PERF_MAX_STALL_EN.
- Defined: each channel gets a run-length counter that counts consecutive ch_stall cycles and resets to 0 when ch_stall is low. A max register keeps the largest completed-or-ongoing run, saturating at 2^CNT_W-1. The max register is cleared by clr and captured by snap. rd_type=4 returns its shadow.
- Undefined: no run or max logic is built, and rd_type=4 returns 0.

Test Plan:
- Reset, then NUM_CH=2, ch_read[0] high for 5 cycles, low 1, high 3; snap; read ch0 type0 -> rd_data=2 one cycle after rd_en; rd_valid pulses once.
- ch_stall[1] high 4 cycles, low 2, high 3; snap; read ch1 type1 -> 2 and type2 -> 7. With PERF_MAX_STALL_EN, type4 -> 4; without it -> 0.
- CNT_W=8, 260 access edges on ch0; snap; read type0 -> 255, type3 -> 1, any_ovf=1. Then clr -> any_ovf=0.
- 10 accesses on ch0; pulse snap and clr together; 3 more accesses; read type0 -> 10. Snap again, read -> 3.
- clr coincident with an access edge on ch0 -> after snap, type0 reads 1. Read rd_ch=5 -> rd_data=0, rd_valid=1.
- Assert rst while ch_write[0]=1 and counters are non-zero -> all outputs 0 immediately. Deassert with ch_write held high, snap -> type0 reads 1.
